// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write BRAM between
// instruction fetch (M0, read-only) and the load/store unit (M1).
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [31:0]           dina,
    output logic [3:0]            wea,
    input  logic [31:0]           douta
);

    // last_gnt = 1 means M1 won most recently, so M0 wins the next contention
    logic last_gnt;
    logic lock_own;
    logic rsp_vld;
    logic rsp_port;
    logic rsp_wr;

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (lock_own) begin
                m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
                m0_gnt = last_gnt;
                m1_gnt = !last_gnt;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    assign addra = m1_gnt ? m1_addr : m0_addr;
    assign wea   = m1_gnt ? m1_wstrb : 4'b0000;
    assign dina  = m1_wdata;

    always_ff @(posedge clka) begin
        if (rst) begin
            last_gnt <= 1'b1;
            lock_own <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_port <= 1'b0;
            rsp_wr   <= 1'b0;
        end else begin
            if (m0_gnt) begin
                last_gnt <= 1'b0;
            end else if (m1_gnt) begin
                last_gnt <= 1'b1;
            end
            // dropping m1_lock releases ownership even without a grant
            if (!m1_lock) begin
                lock_own <= 1'b0;
            end else if (m1_gnt) begin
                lock_own <= 1'b1;
            end
            rsp_vld  <= m0_gnt || m1_gnt;
            rsp_port <= m1_gnt;
            rsp_wr   <= m1_gnt && (m1_wstrb != 4'b0000);
        end
    end

    assign m0_rvalid = rsp_vld && !rsp_port;
    assign m1_rvalid = rsp_vld && rsp_port;
    assign m0_rdata  = douta;
    assign m1_rdata  = rsp_wr ? 32'h0 : douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus random traffic
// against a rule-level arbiter model and a shadow memory.
module tb_bram_port_arbiter;

    localparam int AW = 14;

    logic          clka = 1'b0;
    logic          rst;
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [31:0]   m0_rdata;
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    m1_wstrb;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [31:0]   m1_rdata;
    logic [AW-1:0] addra;
    logic [31:0]   dina;
    logic [3:0]    wea;
    logic [31:0]   douta;

    bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clka(clka), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .addra(addra), .dina(dina), .wea(wea), .douta(douta)
    );

    always #5 clka = ~clka;

    // BRAM: 64 words, read-first, 1-cycle latency, plus a preload port
    logic [31:0] ram [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clka) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else begin
            for (int b = 0; b < 4; b++)
                if (wea[b]) ram[addra[5:0]][b*8 +: 8] <= dina[b*8 +: 8];
        end
        douta <= ram[addra[5:0]];
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [64];
    logic        mlast;
    logic        mlock;
    int          w0, w1;
    logic        g0_obs, g1_obs;
    logic [3:0]  wea_obs;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(posedge clka);
        #1;
        bd_we = 1'b0;
    endtask

    // one cycle: inputs were set just after negedge
    task automatic tick();
        logic        e0, e1, lk;
        logic [3:0]  ew;
        logic [31:0] ed;
        #1;
        lk = mlock;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!rst) begin
            if (mlock) begin
                e1 = m1_req;
            end else if (m0_req && m1_req) begin
                e0 = mlast;
                e1 = !mlast;
            end else begin
                e0 = m0_req;
                e1 = m1_req;
            end
        end
        ew = e1 ? m1_wstrb : 4'b0000;
        check("m0_gnt", {31'b0, m0_gnt}, {31'b0, e0});
        check("m1_gnt", {31'b0, m1_gnt}, {31'b0, e1});
        check("wea", {28'b0, wea}, {28'b0, ew});
        g0_obs  = m0_gnt;
        g1_obs  = m1_gnt;
        wea_obs = wea;
        ed = 32'h0;
        if (e0) ed = ref_mem[m0_addr[5:0]];
        if (e1) begin
            if (m1_wstrb == 4'b0000) begin
                ed = ref_mem[m1_addr[5:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m1_wstrb[b])
                        ref_mem[m1_addr[5:0]][b*8 +: 8] = m1_wdata[b*8 +: 8];
            end
        end
        if (rst || lk) begin
            w0 = 0;
            w1 = 0;
        end else begin
            w0 = (m0_req && !m0_gnt) ? w0 + 1 : 0;
            w1 = (m1_req && !m1_gnt) ? w1 + 1 : 0;
            if (m0_req) check("wait0", {31'b0, w0 <= 1}, 32'd1);
            if (m1_req) check("wait1", {31'b0, w1 <= 1}, 32'd1);
        end
        if (rst) begin
            mlast = 1'b1;
            mlock = 1'b0;
        end else begin
            if (e0) mlast = 1'b0;
            if (e1) mlast = 1'b1;
            if (!m1_lock) mlock = 1'b0;
            else if (e1) mlock = 1'b1;
        end
        @(posedge clka);
        #1;
        check("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, e0});
        check("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, e1});
        if (e0) check("m0_rdata", m0_rdata, ed);
        if (e1) check("m1_rdata", m1_rdata, ed);
        @(negedge clka);
    endtask

    task automatic idle();
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        m1_lock  = 1'b0;
        m1_wstrb = 4'b0000;
    endtask

    logic p0, p1;

    initial begin
        rst      = 1'b1;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        m0_addr  = '0;
        m1_addr  = '0;
        m1_wdata = '0;
        mlast    = 1'b1;
        mlock    = 1'b0;
        w0       = 0;
        w1       = 0;
        idle();
        for (int i = 0; i < 64; i++)
            preload(6'(i), 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101));
        preload(6'h10, 32'hDEAD_BEEF);
        preload(6'h20, 32'hAABB_CCDD);
        @(negedge clka);

        // reset state with both requesting
        m0_req = 1'b1;
        m1_req = 1'b1;
        m1_wstrb = 4'b1111;
        tick();
        check("rst_gnt", {30'b0, g0_obs, g1_obs}, 32'd0);
        check("rst_wea", {28'b0, wea_obs}, 32'd0);
        rst = 1'b0;
        idle();

        // single M0 read
        m0_req  = 1'b1;
        m0_addr = 14'h010;
        tick();
        check("t1_gnt", {31'b0, g0_obs}, 32'd1);
        check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        idle();

        // contention alternation from fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m1_addr = 14'h003;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("alt_m0", {31'b0, g0_obs}, {31'b0, (i % 2) == 0});
        end
        idle();

        // partial write, then read back
        m1_req   = 1'b1;
        m1_addr  = 14'h020;
        m1_wdata = 32'h1122_3344;
        m1_wstrb = 4'b0101;
        tick();
        check("t3_wrsp", m1_rdata, 32'h0);
        m1_wstrb = 4'b0000;
        tick();
        check("t3_rd", m1_rdata, 32'hAA22_CC44);
        idle();

        // lock holds M0 off for 3 grants
        m0_req = 1'b1;
        tick();
        m1_req  = 1'b1;
        m1_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_m0", {31'b0, g0_obs}, 32'd0);
            check("lock_m1", {31'b0, g1_obs}, 32'd1);
        end
        m1_req  = 1'b0;
        m1_lock = 1'b0;
        tick();
        check("unlock_m0_wait", {31'b0, g0_obs}, 32'd0);
        tick();
        check("unlock_m0_gnt", {31'b0, g0_obs}, 32'd1);
        idle();

        // reset right after a grant
        m1_req = 1'b1;
        tick();
        rst    = 1'b1;
        m0_req = 1'b1;
        m1_wstrb = 4'b1111;
        tick();
        check("t5_wea", {28'b0, wea_obs}, 32'd0);
        rst = 1'b0;
        m1_wstrb = 4'b0000;
        tick();
        check("t5_first", {31'b0, g0_obs}, 32'd1);
        idle();

        // random traffic
        p0 = 1'b0;
        p1 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(p0 && $urandom_range(0, 3) != 0)) begin
                m0_req  = $urandom_range(0, 1) == 1;
                m0_addr = 14'($urandom_range(0, 63));
            end
            if (!(p1 && $urandom_range(0, 3) != 0)) begin
                m1_req   = $urandom_range(0, 1) == 1;
                m1_addr  = 14'($urandom_range(0, 63));
                m1_wdata = $urandom;
                m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            end
            m1_lock = $urandom_range(0, 3) == 0;
            tick();
            p0 = m0_req && !g0_obs;
            p1 = m1_req && !g1_obs;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
